// File: rtl/op_sel_stage.sv
// Purpose: selects one of NSRC operands by sel and registers it with its select code.
// Latency: one cycle from input acceptance to out/out_valid. Throughput is one beat per cycle.
// Backpressure: a 2-entry main+skid store absorbs a stall; in_ready drops only when both entries are full.
// Optional feature macro: OPSEL_ERR_EN. When defined, a bad select yields 0 and sets the sticky err flag.
module op_sel_stage #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SELW-1:0]        sel,
  input  logic [NSRC*WIDTH-1:0]  src,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out,
  output logic [SELW-1:0]        out_sel,
  output logic                   err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              in_ready_q;
  logic              accept;
  logic              load_main;
  logic              load_skid;
  logic              skid_to_main;
  logic [WIDTH-1:0]  sel_dat;
  logic [WIDTH-1:0]  main_dat;
  logic [SELW-1:0]   main_sel;
  logic [WIDTH-1:0]  skid_dat;
  logic [SELW-1:0]   skid_sel;

  // in_ready comes from a flop. Reset only masks it, so nothing is accepted while rst is high.
  assign in_ready  = in_ready_q & ~rst;
  assign accept    = in_valid & in_ready;
  // Output valid follows the stored state. It is masked during reset, so no beat hands off in that cycle.
  assign out_valid = (state != ST_EMPTY) & ~rst;
  assign out       = main_dat;
  assign out_sel   = main_sel;

  // Operand mux. An unmatched select falls through to the default value.
  always_comb begin
`ifdef OPSEL_ERR_EN
    sel_dat = '0;
`else
    sel_dat = src[WIDTH-1:0];
`endif
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) begin
        sel_dat = src[k*WIDTH +: WIDTH];
      end
    end
  end

  // Occupancy FSM. It also decides where an accepted beat is written.
  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !out_ready) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (accept && out_ready) begin
          load_main = 1'b1;
        end else if (!accept && out_ready) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain toward main can occur.
        if (out_ready) begin
          state_nxt    = ST_ONE;
          skid_to_main = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  // State, ready flop and the two beat registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_dat   <= '0;
      main_sel   <= '0;
      skid_dat   <= '0;
      skid_sel   <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
      if (load_main) begin
        main_dat <= sel_dat;
        main_sel <= sel;
      end else if (skid_to_main) begin
        main_dat <= skid_dat;
        main_sel <= skid_sel;
      end
      if (load_skid) begin
        skid_dat <= sel_dat;
        skid_sel <= sel;
      end
    end
  end

`ifdef OPSEL_ERR_EN
  localparam logic [SELW:0] NSRC_W = (SELW+1)'(NSRC);
  logic bad_sel;
  logic err_q;

  assign bad_sel = ({1'b0, sel} >= NSRC_W);
  assign err     = err_q;

  // Sticky flag: set by any accepted beat that has a bad select. Only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && bad_sel) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
